grey_frame_streamer: RTL

- Pixel source for the Sobel pipeline. It reads one stored image frame from a synchronous-read memory and emits it raster-order as the grey/done strobe stream that the Sobel kernel consumes.
- Sits between the frame memory (BRAM/ROM) and the kernel's grey_i/done_i inputs.
- Throughput is programmable, so downstream line buffers can be paced.

---
 rtl/sobel_pkg.sv | 26 ++
 rtl/rgb_to_grey.sv | 27 ++
 rtl/grey_frame_streamer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel pixel-source path.
// RGB2GREY_EN selects the RGB-to-grey conversion stage and its extra cycle of latency.
package sobel_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } state_t;

  localparam int unsigned W_R = 77;
  localparam int unsigned W_G = 150;
  localparam int unsigned W_B = 29;

  localparam int unsigned DEF_IMG_W = 64;
  localparam int unsigned DEF_IMG_H = 64;

  // Cycles from a memory read issue to its done_o strobe.
`ifdef RGB2GREY_EN
  localparam int unsigned PIPE_LAT = 3;
`else
  localparam int unsigned PIPE_LAT = 2;
`endif

endpackage

// File: rtl/rgb_to_grey.sv
// Registered weighted RGB-to-grey sum; used only when RGB2GREY_EN is defined.
module rgb_to_grey
  import sobel_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [23:0] rgb,
  output logic [7:0]  grey
);

  logic [15:0] acc;

  // Weights sum to 256, so the top byte of the 16-bit sum never overflows.
  always_comb begin
    acc = 16'(W_R * 32'(rgb[23:16]) + W_G * 32'(rgb[15:8]) + W_B * 32'(rgb[7:0]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grey <= '0;
    end else if (en) begin
      grey <= acc[15:8];
    end
  end

endmodule

// File: rtl/grey_frame_streamer.sv
// Reads one frame from synchronous-read memory and streams it raster-order as grey/done.
// Define RGB2GREY_EN for 24-bit RGB memory words converted to grey (one extra cycle).
module grey_frame_streamer
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W  = DEF_IMG_W,
  parameter int unsigned IMG_H  = DEF_IMG_H,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned GAP    = 0,
  parameter int unsigned MEM_W  = 8
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  input  logic              start_i,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [MEM_W-1:0]  mem_rdata_i,
  output logic [7:0]        grey_o,
  output logic              done_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [15:0]       GAP_LD    = 16'(GAP);

  state_t            state, state_nx;
  logic              rd_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [15:0]       gap_cnt, gap_nx;
  logic              busy_nx;
  logic              fdone_nx;
  logic [PIPE_LAT-1:0] vld_sr;
  logic              pipe_empty;

  // vld_sr[0] is the read issued last cycle; the top bit is the done strobe itself.
  assign done_o     = vld_sr[PIPE_LAT-1];
  assign pipe_empty = !mem_rd_o && !(|vld_sr[PIPE_LAT-2:0]);

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state        <= IDLE;
      mem_rd_o     <= 1'b0;
      mem_addr_o   <= '0;
      gap_cnt      <= '0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
      vld_sr       <= '0;
    end else begin
      state        <= state_nx;
      mem_rd_o     <= rd_nx;
      mem_addr_o   <= addr_nx;
      gap_cnt      <= gap_nx;
      busy_o       <= busy_nx;
      frame_done_o <= fdone_nx;
      vld_sr       <= {vld_sr[PIPE_LAT-2:0], mem_rd_o};
    end
  end

  always_comb begin
    state_nx = state;
    rd_nx    = 1'b0;
    addr_nx  = mem_addr_o;
    gap_nx   = gap_cnt;
    busy_nx  = busy_o;
    fdone_nx = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_nx = RUN;
          rd_nx    = 1'b1;
          addr_nx  = '0;
          gap_nx   = GAP_LD;
          busy_nx  = 1'b1;
        end
      end
      RUN: begin
        if (gap_cnt == '0) begin
          rd_nx   = 1'b1;
          addr_nx = mem_addr_o + 1'b1;
          gap_nx  = GAP_LD;
          if (addr_nx == LAST_ADDR) begin
            state_nx = DRAIN;
          end
        end else begin
          gap_nx = gap_cnt - 1'b1;
        end
      end
      DRAIN: begin
        // Last pixel is on done_o once nothing younger is still in flight.
        if (done_o && pipe_empty) begin
          state_nx = FIN;
          fdone_nx = 1'b1;
        end
      end
      FIN: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

`ifdef RGB2GREY_EN
  logic [7:0] conv_grey;

  rgb_to_grey u_rgb_to_grey (
    .clk  (sys_clk_i),
    .rst  (sys_rst_i),
    .en   (vld_sr[0]),
    .rgb  (mem_rdata_i[23:0]),
    .grey (conv_grey)
  );

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      grey_o <= '0;
    end else if (vld_sr[1]) begin
      grey_o <= conv_grey;
    end
  end
`else
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      grey_o <= '0;
    end else if (vld_sr[0]) begin
      grey_o <= mem_rdata_i[7:0];
    end
  end
`endif

endmodule
